exec_wb_stage: RTL and testbench
================================

Name: exec_wb_stage

Overview:
- Pipeline stage directly downstream of the add/sub execute unit. It captures each result word, its 4-bit flags and the destination register info in a 2-entry skid buffer.
- It presents the oldest entry to register-file writeback under a valid/ready handshake.
- When a flag-writing entry retires, it commits that entry's flags into the architectural flags register.
- It answers a combinational RAW-hazard query for decode against the entries it holds.

Parameters:
- W_OPR, 32, operand/result width.
- W_FLAGS, 4, flags width; ordering {overflow, sign, zero, carry}.
- W_RADDR, 5, register address width.
- DEPTH, 2, buffer entries; fixed at 2; other values unsupported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all buffered entries.
- in_valid_i  in  1  execute result valid.
- in_ready_o  out  1  stage can accept an entry.
- in_result_i  in  W_OPR  execute result.
- in_flags_i  in  W_FLAGS  execute flags.
- in_rd_i  in  W_RADDR  destination register.
- in_rd_we_i  in  1  entry writes a register.
- in_flags_we_i  in  1  entry updates the flags register.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  register file accepts head.
- wb_result_o  out  W_OPR  head result.
- wb_rd_o  out  W_RADDR  head destination.
- wb_rd_we_o  out  1  head register write enable; already qualified by wb_valid_o.
- flags_o  out  W_FLAGS  committed architectural flags.
- haz_addr_i  in  W_RADDR  decode source-register query.
- haz_o  out  1  a buffered entry will write haz_addr_i.

Behaviour:
- Reset (rst_n_i low, asynchronous), all of the following go to 0:
  - count, head pointer, flags register, all entry storage.
  - wb_valid_o, wb_result_o, wb_rd_o, wb_rd_we_o, flags_o, haz_o.
  - in_ready_o is 1 once reset is released.
  - Reset asserted mid-transfer drops every entry; no flag commit occurs.
- Storage:
  - Circular 2-entry buffer with head pointer and count 0..2.
  - Push writes slot (head+count) mod 2.
  - Pop advances the head mod 2.
- Handshake:
  - push = in_valid_i & in_ready_o.
  - pop = wb_valid_o & wb_ready_i.
  - in_ready_o = (count != 2), purely registered-state based; no combinational path from wb_ready_i.
  - wb_valid_o = (count != 0).
  - Head fields are driven combinationally from the head slot. When empty, fields are 0.
- Latency: an entry pushed in cycle N is visible on wb_* in cycle N+1 at the earliest. There is no bypass from input to output.
- Count update on a non-flush cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; legal at count 1.
  - At count 2 only a pop can occur.
  - At count 0 no pop can occur.
- Flags commit:
  - On pop, if the head's in_flags_we was set, the flags register takes the head flags at the clock edge.
  - flags_o reflects the new value from the next cycle.
  - Entries with in_flags_we_i = 0 never alter the flags.
- Flush:
  - Highest priority. Count becomes 0 and the head pointer becomes 0.
  - A same-cycle push is dropped.
  - A same-cycle pop still counts as retired: its register write was seen by the register file, and its flag commit happens.
  - The flags register is otherwise unchanged.
- Hazard:
  - haz_o = OR over valid entries of (rd_we & rd == haz_addr_i).
  - Register address 0 is never a hazard (hardwired zero register).
- Values are stored verbatim; no arithmetic is performed on result or flags.

Decomposition:
- W_OPR, W_FLAGS, W_RADDR and the flag bit indices (FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_V=3) belong in the shared params include, also used by the execute unit.
- One natural sub-module: wb_skid_buf. It holds the 2-entry storage, pointers and count, with a generic payload width.
- exec_wb_stage adds the flags register, the commit logic and the hazard compare.

Test Plan:
- Reset, then push result 0x0000_0005, flags 4'b0000, rd 3, rd_we=1, flags_we=1, with wb_ready_i=1 → next cycle wb_valid_o=1, wb_result_o=5, wb_rd_o=3. After the pop, flags_o=0 and count returns to 0.
- Hold wb_ready_i=0 and push two entries (0xFFFF_FFFF flags 4'b0101; 0x8000_0000 flags 4'b1100) → in_ready_o=0 after the second push. Release ready → entries pop in order. flags_o becomes 4'b0101, then 4'b1100.
- Steady stream with in_valid_i=1 and wb_ready_i=1 for 8 cycles → one retire per cycle, count stays 1, in_ready_o stays 1, results appear in order.
- Buffer holds rd 7 with rd_we=1 → haz_addr_i=7 gives haz_o=1; haz_addr_i=6 gives 0. An entry with rd 0 → haz_o=0.
- Count 2 with flags_we entries; assert flush_i with wb_ready_i=0 → next cycle wb_valid_o=0, in_ready_o=1, flags_o unchanged.
- Assert rst_n_i low asynchronously mid-cycle while count=1 → outputs go to 0 immediately, before any clock edge; flags_o=0.

Source files
------------

// File: rtl/exec_wb_stage_pkg.sv
// =============================================================================
// Module   : exec_wb_stage_pkg
// Brief    : Shared widths and flag bit indices for the execute/writeback path.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package exec_wb_stage_pkg;

  localparam int W_OPR   = 32;
  localparam int W_FLAGS = 4;
  localparam int W_RADDR = 5;

  // Flag bit positions within {overflow, sign, zero, carry}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  // Register 0 is hardwired to zero, so writes to it never create a hazard.
  function automatic logic hazard_match(input logic            rd_we,
                                        input logic [W_RADDR-1:0] rd,
                                        input logic [W_RADDR-1:0] addr);
    return rd_we && (rd == addr) && (addr != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_wb_stage_skid_buf.sv
// =============================================================================
// Module   : wb_skid_buf
// Brief    : Circular skid buffer with generic payload; exposes per-slot tags.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_skid_buf #(
  parameter int W_PAYLOAD = 8,
  parameter int W_TAG     = 1,
  parameter int DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_flush,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [W_PAYLOAD-1:0]             i_payload,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [W_PAYLOAD-1:0]             o_head,
  output logic [DEPTH-1:0]                 o_slot_valid,
  output logic [DEPTH-1:0][W_TAG-1:0]      o_slot_tag
);

  localparam int W_CNT = $clog2(DEPTH + 1);
  localparam int W_PTR = $clog2(DEPTH);

  logic [DEPTH-1:0][W_PAYLOAD-1:0] r_mem;
  logic [W_PTR-1:0]                r_head;
  logic [W_CNT-1:0]                r_count;
  logic [W_PTR-1:0]                w_tail;

  assign w_tail  = r_head + W_PTR'(r_count);
  assign o_full  = (r_count == W_CNT'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else begin
      if (i_push && !i_flush)
        r_mem[w_tail] <= i_payload;
      if (i_flush) begin
        r_head  <= '0;
        r_count <= '0;
      end else begin
        if (i_pop)
          r_head <= r_head + W_PTR'(1);
        case ({i_push, i_pop})
          2'b10:   r_count <= r_count + W_CNT'(1);
          2'b01:   r_count <= r_count - W_CNT'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // A slot is live when its distance from the head is below the fill count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [W_PTR-1:0] w_off;
    assign w_off           = W_PTR'(i) - r_head;
    assign o_slot_valid[i] = (W_CNT'(w_off) < r_count);
    assign o_slot_tag[i]   = r_mem[i][W_PAYLOAD-1 -: W_TAG];
  end

endmodule

`default_nettype wire

// File: rtl/exec_wb_stage.sv
// =============================================================================
// Module   : exec_wb_stage
// Brief    : Writeback stage: 2-entry skid buffer, flags commit, RAW hazard query.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module exec_wb_stage
  import exec_wb_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [W_OPR-1:0]   in_result_i,
  input  logic [W_FLAGS-1:0] in_flags_i,
  input  logic [W_RADDR-1:0] in_rd_i,
  input  logic               in_rd_we_i,
  input  logic               in_flags_we_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [W_OPR-1:0]   wb_result_o,
  output logic [W_RADDR-1:0] wb_rd_o,
  output logic               wb_rd_we_o,
  output logic [W_FLAGS-1:0] flags_o,
  input  logic [W_RADDR-1:0] haz_addr_i,
  output logic               haz_o
);

  localparam int C_W_TAG = 1 + W_RADDR;
  localparam int C_W_PAY = C_W_TAG + 1 + W_FLAGS + W_OPR;

  logic                            w_push;
  logic                            w_pop;
  logic                            w_full;
  logic                            w_empty;
  logic [C_W_PAY-1:0]              w_in_pay;
  logic [C_W_PAY-1:0]              w_head;
  logic [DEPTH-1:0]                w_slot_valid;
  logic [DEPTH-1:0][C_W_TAG-1:0]   w_slot_tag;
  logic [DEPTH-1:0]                w_hit;
  logic                            w_head_flags_we;
  logic [W_FLAGS-1:0]              w_head_flags;
  logic [W_FLAGS-1:0]              r_flags;

  // Hazard fields sit at the top of the payload so the buffer can expose them as tags.
  assign w_in_pay = {in_rd_we_i, in_rd_i, in_flags_we_i, in_flags_i, in_result_i};

  assign in_ready_o = ~w_full;
  assign wb_valid_o = ~w_empty;
  assign w_push     = in_valid_i & in_ready_o;
  assign w_pop      = wb_valid_o & wb_ready_i;

  assign {wb_rd_we_o, wb_rd_o, w_head_flags_we, w_head_flags, wb_result_o} = w_head;

  wb_skid_buf #(
    .W_PAYLOAD (C_W_PAY),
    .W_TAG     (C_W_TAG),
    .DEPTH     (DEPTH)
  ) u_buf (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .i_flush      (flush_i),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_payload    (w_in_pay),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head       (w_head),
    .o_slot_valid (w_slot_valid),
    .o_slot_tag   (w_slot_tag)
  );

  // A pop retires the head even under flush, so its flag commit still lands.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_flags <= '0;
    else if (w_pop && w_head_flags_we)
      r_flags <= w_head_flags;
  end

  assign flags_o = r_flags;

  for (genvar i = 0; i < DEPTH; i++) begin : g_haz
    assign w_hit[i] = w_slot_valid[i] &
                      hazard_match(w_slot_tag[i][C_W_TAG-1], w_slot_tag[i][W_RADDR-1:0], haz_addr_i);
  end

  assign haz_o = |w_hit;

endmodule

`default_nettype wire

// File: tb/tb_exec_wb_stage.sv
// =============================================================================
// Module   : tb_exec_wb_stage
// Brief    : Directed self-checking bench for exec_wb_stage.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_exec_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_result_i;
  logic [3:0]  in_flags_i;
  logic [4:0]  in_rd_i;
  logic        in_rd_we_i;
  logic        in_flags_we_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_o;
  logic        wb_rd_we_o;
  logic [3:0]  flags_o;
  logic [4:0]  haz_addr_i;
  logic        haz_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  exec_wb_stage dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_result_i   (in_result_i),
    .in_flags_i    (in_flags_i),
    .in_rd_i       (in_rd_i),
    .in_rd_we_i    (in_rd_we_i),
    .in_flags_we_i (in_flags_we_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_result_o   (wb_result_o),
    .wb_rd_o       (wb_rd_o),
    .wb_rd_we_o    (wb_rd_we_o),
    .flags_o       (flags_o),
    .haz_addr_i    (haz_addr_i),
    .haz_o         (haz_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] fl,
                       input logic [4:0] rd, input logic rwe, input logic fwe);
    in_valid_i    = v;
    in_result_i   = res;
    in_flags_i    = fl;
    in_rd_i       = rd;
    in_rd_we_i    = rwe;
    in_flags_we_i = fwe;
  endtask

  initial begin
    rst_n_i    = 1'b0;
    flush_i    = 1'b0;
    wb_ready_i = 1'b0;
    haz_addr_i = 5'd0;
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    #3;
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_result", wb_result_o, 32'd0);
    check("rst_flags", 32'(flags_o), 32'd0);
    check("rst_haz", 32'(haz_o), 32'd0);
    #9 rst_n_i = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);

    // Single entry, immediately accepted downstream
    wb_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0005, 4'b0000, 5'd3, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    check("s1_valid", 32'(wb_valid_o), 32'd1);
    check("s1_result", wb_result_o, 32'd5);
    check("s1_rd", 32'(wb_rd_o), 32'd3);
    check("s1_rd_we", 32'(wb_rd_we_o), 32'd1);
    tick();
    check("s1_empty", 32'(wb_valid_o), 32'd0);
    check("s1_flags", 32'(flags_o), 32'd0);
    check("s1_ready", 32'(in_ready_o), 32'd1);

    // Fill both slots under backpressure
    wb_ready_i = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 4'b0101, 5'd1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h8000_0000, 4'b1100, 5'd2, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    check("s2_full_ready", 32'(in_ready_o), 32'd0);
    check("s2_head", wb_result_o, 32'hFFFF_FFFF);
    haz_addr_i = 5'd2;
    #1 check("s2_haz_tail", 32'(haz_o), 32'd1);
    haz_addr_i = 5'd6;
    #1 check("s2_haz_miss", 32'(haz_o), 32'd0);
    wb_ready_i = 1'b1;
    #1 check("s2_no_comb_ready", 32'(in_ready_o), 32'd0);
    tick();
    check("s2_flags_a", 32'(flags_o), 32'h5);
    check("s2_head_b", wb_result_o, 32'h8000_0000);
    check("s2_ready_after", 32'(in_ready_o), 32'd1);
    tick();
    check("s2_flags_b", 32'(flags_o), 32'hC);
    check("s2_empty", 32'(wb_valid_o), 32'd0);

    // Streaming: one retire per cycle, no flag updates
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'd100 + 32'(i), 4'b0011, 5'd4, 1'b1, 1'b0);
      tick();
      check("st_result", wb_result_o, 32'd100 + 32'(i));
      check("st_ready", 32'(in_ready_o), 32'd1);
    end
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick();
    check("st_drained", 32'(wb_valid_o), 32'd0);
    check("st_flags_kept", 32'(flags_o), 32'hC);

    // Hazard query
    wb_ready_i = 1'b0;
    drive(1'b1, 32'h1234, 4'h0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    haz_addr_i = 5'd7;
    #1 check("hz_hit", 32'(haz_o), 32'd1);
    haz_addr_i = 5'd6;
    #1 check("hz_miss", 32'(haz_o), 32'd0);
    wb_ready_i = 1'b1;
    tick();
    haz_addr_i = 5'd7;
    #1 check("hz_after_pop", 32'(haz_o), 32'd0);
    wb_ready_i = 1'b0;
    drive(1'b1, 32'h55, 4'h0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    haz_addr_i = 5'd0;
    #1 check("hz_r0", 32'(haz_o), 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("hz_flushed", 32'(wb_valid_o), 32'd0);

    // Flush at count 2 without pop: flags untouched, same-cycle push dropped
    drive(1'b1, 32'hA, 4'b0011, 5'd8, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'hB, 4'b1001, 5'd9, 1'b1, 1'b1);
    tick();
    check("fl_full", 32'(in_ready_o), 32'd0);
    flush_i = 1'b1;
    tick();
    check("fl_valid", 32'(wb_valid_o), 32'd0);
    check("fl_ready", 32'(in_ready_o), 32'd1);
    check("fl_flags", 32'(flags_o), 32'hC);
    // in_valid still high during this flush cycle, so that push must vanish too
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    check("fl_push_dropped", 32'(wb_valid_o), 32'd0);

    // Flush coinciding with a pop still commits the head's flags
    drive(1'b1, 32'hC, 4'b0110, 5'd10, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    flush_i    = 1'b1;
    wb_ready_i = 1'b1;
    tick();
    flush_i    = 1'b0;
    wb_ready_i = 1'b0;
    check("flp_flags", 32'(flags_o), 32'h6);
    check("flp_empty", 32'(wb_valid_o), 32'd0);

    // Asynchronous reset mid-cycle
    drive(1'b1, 32'hDEAD_BEEF, 4'b1111, 5'd12, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    haz_addr_i = 5'd12;
    #1 check("ar_pre_valid", 32'(wb_valid_o), 32'd1);
    check("ar_pre_haz", 32'(haz_o), 32'd1);
    #1 rst_n_i = 1'b0;
    #1;
    check("ar_valid", 32'(wb_valid_o), 32'd0);
    check("ar_result", wb_result_o, 32'd0);
    check("ar_rd_we", 32'(wb_rd_we_o), 32'd0);
    check("ar_flags", 32'(flags_o), 32'd0);
    check("ar_haz", 32'(haz_o), 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    check("ar_release_ready", 32'(in_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
